// File: rtl/tri_raster_ctrl_if.sv
// Bus bundle for the triangle raster controller: triangle offer, tester
// request/result and covered-pixel stream, with controller/driver views.
interface tri_raster_ctrl_if #(
  parameter int SYS_BIT_WIDTH = 32
);
  logic                         tri_valid_in;
  logic                         tri_ready_out;
  logic [SYS_BIT_WIDTH-1:0]     vertex_ax;
  logic [SYS_BIT_WIDTH-1:0]     vertex_ay;
  logic [SYS_BIT_WIDTH-1:0]     vertex_bx;
  logic [SYS_BIT_WIDTH-1:0]     vertex_by;
  logic [SYS_BIT_WIDTH-1:0]     vertex_cx;
  logic [SYS_BIT_WIDTH-1:0]     vertex_cy;

  logic                         test_valid_out;
  logic [SYS_BIT_WIDTH-1:0]     test_vertex_ax;
  logic [SYS_BIT_WIDTH-1:0]     test_vertex_ay;
  logic [SYS_BIT_WIDTH-1:0]     test_vertex_bx;
  logic [SYS_BIT_WIDTH-1:0]     test_vertex_by;
  logic [SYS_BIT_WIDTH-1:0]     test_vertex_cx;
  logic [SYS_BIT_WIDTH-1:0]     test_vertex_cy;
  logic [SYS_BIT_WIDTH-1:0]     test_point_x;
  logic [SYS_BIT_WIDTH-1:0]     test_point_y;
  logic                         test_valid_in;
  logic                         test_inside_in;

  logic                         pixel_valid_out;
  logic [SYS_BIT_WIDTH-1:0]     pixel_x_out;
  logic [SYS_BIT_WIDTH-1:0]     pixel_y_out;
  logic                         pixel_ready_in;

  logic                         done_out;
  logic                         error_out;
  logic [2*SYS_BIT_WIDTH-1:0]   pixel_count_out;

  modport slave (
    input  tri_valid_in, vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy,
    input  test_valid_in, test_inside_in, pixel_ready_in,
    output tri_ready_out, test_valid_out,
    output test_vertex_ax, test_vertex_ay, test_vertex_bx, test_vertex_by,
    output test_vertex_cx, test_vertex_cy, test_point_x, test_point_y,
    output pixel_valid_out, pixel_x_out, pixel_y_out,
    output done_out, error_out, pixel_count_out
  );

  modport master (
    output tri_valid_in, vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy,
    output test_valid_in, test_inside_in, pixel_ready_in,
    input  tri_ready_out, test_valid_out,
    input  test_vertex_ax, test_vertex_ay, test_vertex_bx, test_vertex_by,
    input  test_vertex_cx, test_vertex_cy, test_point_x, test_point_y,
    input  pixel_valid_out, pixel_x_out, pixel_y_out,
    input  done_out, error_out, pixel_count_out
  );
endinterface

// File: rtl/tri_raster_ctrl.sv
// Triangle raster controller: scans the screen-clipped bounding box in row-major
// order, asks an external point-in-triangle tester per pixel, streams covered pixels.
module tri_raster_ctrl #(
  parameter int SYS_BIT_WIDTH = 32,
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int TIMEOUT       = 15
) (
  input logic              clk_in,
  input logic              rst_n_in,
  tri_raster_ctrl_if.slave bus
);

  localparam int W  = SYS_BIT_WIDTH;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [W-1:0]   X_LAST   = W'(SCREEN_W - 1);
  localparam logic [W-1:0]   Y_LAST   = W'(SCREEN_H - 1);
  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_CNT  = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  ONE_TMO  = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BBOX   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_e;

  function automatic logic [W-1:0] umin3(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] umax3(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_e         state_q;
  logic           ready_q;
  logic           test_valid_q;
  logic           pixel_valid_q;
  logic           done_q;
  logic           error_q;
  logic [W-1:0]   vax_q, vay_q, vbx_q, vby_q, vcx_q, vcy_q;
  logic [W-1:0]   tpx_q, tpy_q;
  logic [W-1:0]   pix_x_q, pix_y_q;
  logic [2*W-1:0] count_q;
  logic [W-1:0]   x_q, y_q, xmin_q, xmax_q, ymin_q, ymax_q;
  logic [TW-1:0]  tmo_q;

  logic [W-1:0]   bb_xmin_s, bb_xmax_s, bb_ymin_s, bb_ymax_s;
  logic [W-1:0]   bb_xmax_clip_s, bb_ymax_clip_s;
  logic           bb_off_s;
  logic           row_end_s;
  logic           last_s;
  logic [W-1:0]   next_x_s, next_y_s;

  // Bounding box is derived from the latched vertices, so it is stable during BBOX.
  assign bb_xmin_s      = umin3(vax_q, vbx_q, vcx_q);
  assign bb_xmax_s      = umax3(vax_q, vbx_q, vcx_q);
  assign bb_ymin_s      = umin3(vay_q, vby_q, vcy_q);
  assign bb_ymax_s      = umax3(vay_q, vby_q, vcy_q);
  assign bb_xmax_clip_s = (bb_xmax_s > X_LAST) ? X_LAST : bb_xmax_s;
  assign bb_ymax_clip_s = (bb_ymax_s > Y_LAST) ? Y_LAST : bb_ymax_s;
  assign bb_off_s       = (bb_xmin_s > X_LAST) || (bb_ymin_s > Y_LAST);

  assign row_end_s = (x_q == xmax_q);
  assign last_s    = row_end_s && (y_q == ymax_q);
  assign next_x_s  = row_end_s ? xmin_q : (x_q + ONE_W);
  assign next_y_s  = row_end_s ? (y_q + ONE_W) : y_q;

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      test_valid_q  <= 1'b0;
      pixel_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      vax_q         <= '0;
      vay_q         <= '0;
      vbx_q         <= '0;
      vby_q         <= '0;
      vcx_q         <= '0;
      vcy_q         <= '0;
      tpx_q         <= '0;
      tpy_q         <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      count_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      xmin_q        <= '0;
      xmax_q        <= '0;
      ymin_q        <= '0;
      ymax_q        <= '0;
      tmo_q         <= '0;
    end else begin
      done_q       <= 1'b0;
      test_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.tri_valid_in) begin
            vax_q   <= bus.vertex_ax;
            vay_q   <= bus.vertex_ay;
            vbx_q   <= bus.vertex_bx;
            vby_q   <= bus.vertex_by;
            vcx_q   <= bus.vertex_cx;
            vcy_q   <= bus.vertex_cy;
            count_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_BBOX;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_BBOX: begin
          xmin_q <= bb_xmin_s;
          xmax_q <= bb_xmax_clip_s;
          ymin_q <= bb_ymin_s;
          ymax_q <= bb_ymax_clip_s;
          x_q    <= bb_xmin_s;
          y_q    <= bb_ymin_s;
          if (bb_off_s) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            tpx_q        <= bb_xmin_s;
            tpy_q        <= bb_ymin_s;
            test_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.test_valid_in) begin
            if (bus.test_inside_in) begin
              pixel_valid_q <= 1'b1;
              pix_x_q       <= x_q;
              pix_y_q       <= y_q;
              state_q       <= S_EMIT;
            end else begin
              state_q <= S_NEXT;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Tester went silent: abandon the triangle and latch the fault.
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + ONE_TMO;
          end
        end
        S_EMIT: begin
          if (bus.pixel_ready_in) begin
            pixel_valid_q <= 1'b0;
            count_q       <= count_q + ONE_CNT;
            state_q       <= S_NEXT;
          end else begin
            pixel_valid_q <= 1'b1;
          end
        end
        S_NEXT: begin
          if (last_s) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            x_q          <= next_x_s;
            y_q          <= next_y_s;
            tpx_q        <= next_x_s;
            tpy_q        <= next_y_s;
            test_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_FINISH: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          pixel_valid_q <= 1'b0;
          ready_q       <= 1'b1;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tri_ready_out   = ready_q;
  assign bus.test_valid_out  = test_valid_q;
  assign bus.test_vertex_ax  = vax_q;
  assign bus.test_vertex_ay  = vay_q;
  assign bus.test_vertex_bx  = vbx_q;
  assign bus.test_vertex_by  = vby_q;
  assign bus.test_vertex_cx  = vcx_q;
  assign bus.test_vertex_cy  = vcy_q;
  assign bus.test_point_x    = tpx_q;
  assign bus.test_point_y    = tpy_q;
  assign bus.pixel_valid_out = pixel_valid_q;
  assign bus.pixel_x_out     = pix_x_q;
  assign bus.pixel_y_out     = pix_y_q;
  assign bus.done_out        = done_q;
  assign bus.error_out       = error_q;
  assign bus.pixel_count_out = count_q;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Self-checking bench for tri_raster_ctrl: edge-function tester model, stalling
// pixel sink, and a bounding-box scan model producing expected request/pixel lists.
module tb_tri_raster_ctrl;
  localparam int W   = 32;
  localparam int SW  = 320;
  localparam int SH  = 240;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri_raster_ctrl_if #(.SYS_BIT_WIDTH(W)) bus();

  tri_raster_ctrl #(.SYS_BIT_WIDTH(W), .SCREEN_W(SW), .SCREEN_H(SH), .TIMEOUT(TMO)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // bench controls (written by the test sequence only)
  int tri_seq    = 0;
  bit respond_en = 1'b1;
  int lat_cfg    = 2;
  int stall_cfg  = 0;
  bit rand_stall = 1'b0;
  bit spur_en    = 1'b0;
  bit inj_resp   = 1'b0;

  // monitor-owned observations
  int mon_seq = 0;
  int req_x[$], req_y[$], pix_x[$], pix_y[$];
  int done_cnt, stall_req_cnt, first_hold, last_req_cyc, err_cyc;
  bit unstable, err_seen;
  bit pend, pin;
  int pcnt, hold, cur_stall, hx, hy;

  // expected lists (test sequence only)
  int exp_rx[$], exp_ry[$], exp_px[$], exp_py[$];

  function automatic bit inside_f(longint ax, longint ay, longint bx, longint by,
                                  longint cx, longint cy, longint px, longint py);
    longint e0, e1, e2;
    e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
    e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  function automatic bit same_q(int a[$], int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // tester model, pixel sink and event recorder
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      hold = 0;
      bus.test_valid_in  = 1'b0;
      bus.test_inside_in = 1'b0;
      bus.pixel_ready_in = 1'b0;
    end else begin
      if (mon_seq != tri_seq) begin
        req_x.delete(); req_y.delete(); pix_x.delete(); pix_y.delete();
        done_cnt = 0; stall_req_cnt = 0; first_hold = -1; unstable = 1'b0;
        err_seen = 1'b0; err_cyc = -1; last_req_cyc = -1; hold = 0;
        mon_seq = tri_seq;
      end
      bus.test_valid_in  = 1'b0;
      bus.test_inside_in = 1'b0;
      if (pend) begin
        pcnt = pcnt - 1;
        if (pcnt <= 0) begin
          bus.test_valid_in  = 1'b1;
          bus.test_inside_in = pin;
          pend = 1'b0;
        end
      end else if (inj_resp || (spur_en && $urandom_range(0, 2) == 0)) begin
        bus.test_valid_in  = 1'b1;
        bus.test_inside_in = 1'b1;
      end
      if (bus.test_valid_out) begin
        req_x.push_back(int'(bus.test_point_x));
        req_y.push_back(int'(bus.test_point_y));
        last_req_cyc = cyc;
        if (bus.pixel_valid_out) stall_req_cnt++;
        if (respond_en) begin
          pend = 1'b1;
          pcnt = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
          pin  = inside_f(longint'(bus.test_vertex_ax), longint'(bus.test_vertex_ay),
                          longint'(bus.test_vertex_bx), longint'(bus.test_vertex_by),
                          longint'(bus.test_vertex_cx), longint'(bus.test_vertex_cy),
                          longint'(bus.test_point_x), longint'(bus.test_point_y));
        end
      end
      if (bus.done_out) done_cnt++;
      if (bus.error_out && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
      if (bus.pixel_valid_out) begin
        if (hold == 0) begin
          hx = int'(bus.pixel_x_out);
          hy = int'(bus.pixel_y_out);
          cur_stall = (pix_x.size() == 0) ? stall_cfg :
                      (rand_stall ? int'($urandom_range(0, 2)) : 0);
        end else if (int'(bus.pixel_x_out) != hx || int'(bus.pixel_y_out) != hy) begin
          unstable = 1'b1;
        end
        hold = hold + 1;
        bus.pixel_ready_in = (hold > cur_stall);
        if (bus.pixel_ready_in) begin
          pix_x.push_back(hx);
          pix_y.push_back(hy);
          if (pix_x.size() == 1) first_hold = hold;
          hold = 0;
        end
      end else begin
        bus.pixel_ready_in = 1'b1;
      end
    end
  end

  task automatic build_exp(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
    int xmin, xmax, ymin, ymax;
    exp_rx.delete(); exp_ry.delete(); exp_px.delete(); exp_py.delete();
    xmin = (ax < bx) ? ((ax < cx) ? ax : cx) : ((bx < cx) ? bx : cx);
    ymin = (ay < by) ? ((ay < cy) ? ay : cy) : ((by < cy) ? by : cy);
    xmax = (ax > bx) ? ((ax > cx) ? ax : cx) : ((bx > cx) ? bx : cx);
    ymax = (ay > by) ? ((ay > cy) ? ay : cy) : ((by > cy) ? by : cy);
    if (xmax > SW - 1) xmax = SW - 1;
    if (ymax > SH - 1) ymax = SH - 1;
    if (xmin > SW - 1 || ymin > SH - 1) return;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        exp_rx.push_back(x);
        exp_ry.push_back(y);
        if (inside_f(ax, ay, bx, by, cx, cy, x, y)) begin
          exp_px.push_back(x);
          exp_py.push_back(y);
        end
      end
    end
  endtask

  task automatic accept_tri(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy, output int acc_cyc,
                            output bit err_after);
    int guard = 0;
    tri_seq++;
    @(negedge clk);
    @(negedge clk);
    while (!bus.tri_ready_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.vertex_ax = W'(ax); bus.vertex_ay = W'(ay);
    bus.vertex_bx = W'(bx); bus.vertex_by = W'(by);
    bus.vertex_cx = W'(cx); bus.vertex_cy = W'(cy);
    bus.tri_valid_in = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    bus.tri_valid_in = 1'b0;
    err_after = bus.error_out;
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, output int acc_cyc,
                         output int done_cyc, output bit err_after);
    accept_tri(ax, ay, bx, by, cx, cy, acc_cyc, err_after);
    done_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      if (bus.done_out) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_wait: no done_out within 3000 cycles, required a pulse");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.tri_ready_out !== 1'b1 || bus.test_valid_out !== 1'b0 || bus.pixel_valid_out !== 1'b0 ||
        bus.done_out !== 1'b0 || bus.error_out !== 1'b0 || bus.pixel_count_out !== '0 ||
        bus.test_point_x !== '0 || bus.test_vertex_cy !== '0 || bus.pixel_x_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b tv=%b pv=%b done=%b err=%b cnt=%0d, required ready=1 others 0",
               bus.tri_ready_out, bus.test_valid_out, bus.pixel_valid_out, bus.done_out,
               bus.error_out, bus.pixel_count_out);
    end
    rst_n = 1'b1;
    inj_resp = 1'b1;
    repeat (3) @(negedge clk);
    inj_resp = 1'b0;
    n_checks++;
    if (bus.tri_ready_out !== 1'b1 || bus.pixel_valid_out !== 1'b0 || bus.test_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_spurious_result: ready=%b pv=%b tv=%b, required 1 0 0",
               bus.tri_ready_out, bus.pixel_valid_out, bus.test_valid_out);
    end
  endtask

  task automatic test_basic();
    int a, d; bit e;
    lat_cfg = 2; stall_cfg = 0;
    build_exp(2, 2, 5, 2, 2, 5);
    run_tri(2, 2, 5, 2, 2, 5, a, d, e);
    n_checks++;
    if (!same_q(req_x, exp_rx) || !same_q(req_y, exp_ry) || req_x.size() != 16) begin
      n_fail++;
      $display("FAIL basic_requests: got %0d requests, required 16 in row-major order", req_x.size());
    end
    n_checks++;
    if (!same_q(pix_x, exp_px) || !same_q(pix_y, exp_py) || pix_x.size() != 10) begin
      n_fail++;
      $display("FAIL basic_pixels: got %0d pixels, required 10 matching model", pix_x.size());
    end
    n_checks++;
    if (bus.pixel_count_out !== 64'd10) begin
      n_fail++;
      $display("FAIL basic_count: got %0d, required 10", bus.pixel_count_out);
    end
    n_checks++;
    if (done_cnt != 1 || bus.error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done pulses %0d err %b, required 1 and 0", done_cnt, bus.error_out);
    end
  endtask

  task automatic test_stall();
    int a, d; bit e;
    lat_cfg = 2; stall_cfg = 3;
    build_exp(2, 2, 5, 2, 2, 5);
    run_tri(2, 2, 5, 2, 2, 5, a, d, e);
    stall_cfg = 0;
    n_checks++;
    if (first_hold != 4 || unstable || pix_x.size() == 0 || pix_x[0] != 2 || pix_y[0] != 2) begin
      n_fail++;
      $display("FAIL stall_hold: first pixel held %0d cycles unstable=%b, required (2,2) stable for 4",
               first_hold, unstable);
    end
    n_checks++;
    if (stall_req_cnt != 0 || !same_q(req_x, exp_rx) || !same_q(pix_x, exp_px) ||
        bus.pixel_count_out !== 64'd10) begin
      n_fail++;
      $display("FAIL stall_flow: stall requests %0d count %0d, required 0 and 10",
               stall_req_cnt, bus.pixel_count_out);
    end
  endtask

  task automatic test_offscreen();
    int a, d; bit e;
    run_tri(400, 10, 500, 20, 450, 30, a, d, e);
    n_checks++;
    if (req_x.size() != 0 || d - a != 2) begin
      n_fail++;
      $display("FAIL offscreen: requests %0d done after %0d cycles, required 0 and 2",
               req_x.size(), d - a);
    end
    n_checks++;
    if (bus.pixel_count_out !== '0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL offscreen_count: count %0d done %0d, required 0 and 1",
               bus.pixel_count_out, done_cnt);
    end
  endtask

  task automatic test_clip();
    int a, d; bit e;
    int cx[$], cy[$];
    cx = '{318, 319, 318, 319};
    cy = '{0, 0, 1, 1};
    lat_cfg = 0;
    build_exp(318, 0, 330, 0, 318, 1);
    run_tri(318, 0, 330, 0, 318, 1, a, d, e);
    lat_cfg = 2;
    n_checks++;
    if (!same_q(req_x, cx) || !same_q(req_y, cy)) begin
      n_fail++;
      $display("FAIL clip_requests: got %0d requests, required (318,0)(319,0)(318,1)(319,1)",
               req_x.size());
    end
    n_checks++;
    if (!same_q(pix_x, exp_px) || bus.pixel_count_out !== 64'(exp_px.size())) begin
      n_fail++;
      $display("FAIL clip_pixels: count %0d, required %0d", bus.pixel_count_out, exp_px.size());
    end
  endtask

  task automatic test_timeout();
    int a, d; bit e;
    respond_en = 1'b0;
    run_tri(10, 10, 12, 10, 10, 12, a, d, e);
    respond_en = 1'b1;
    n_checks++;
    if (bus.error_out !== 1'b1 || err_cyc - last_req_cyc != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_error: err=%b rose %0d cycles after request, required 1 after %0d",
               bus.error_out, err_cyc - last_req_cyc, TMO + 1);
    end
    n_checks++;
    if (req_x.size() != 1 || done_cnt != 1 || d != err_cyc) begin
      n_fail++;
      $display("FAIL timeout_abandon: requests %0d done %0d, required 1 and 1 with error",
               req_x.size(), done_cnt);
    end
    run_tri(2, 2, 5, 2, 2, 5, a, d, e);
    n_checks++;
    if (e !== 1'b0 || bus.error_out !== 1'b0 || bus.pixel_count_out !== 64'd10) begin
      n_fail++;
      $display("FAIL timeout_clear: err after accept %b now %b count %0d, required 0 0 10",
               e, bus.error_out, bus.pixel_count_out);
    end
  endtask

  task automatic test_reset_mid_emit();
    int a; bit e; bit seen = 1'b0; bit bad = 1'b0;
    stall_cfg = 1000;
    accept_tri(2, 2, 5, 2, 2, 5, a, e);
    for (int i = 0; i < 200; i++) begin
      if (bus.pixel_valid_out) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!seen || bus.pixel_valid_out !== 1'b0 || bus.pixel_x_out !== '0 || bus.tri_ready_out !== 1'b1 ||
        bus.test_vertex_ax !== '0 || bus.done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_emit: seen=%b pv=%b px=%0d ready=%b vax=%0d, required 1 0 0 1 0",
               seen, bus.pixel_valid_out, bus.pixel_x_out, bus.tri_ready_out, bus.test_vertex_ax);
    end
    stall_cfg = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    inj_resp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inj_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.pixel_valid_out || bus.test_valid_out || !bus.tri_ready_out) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_after: activity=%b done pulses %0d, required 0 and 0", bad, done_cnt);
    end
  endtask

  task automatic test_random();
    int xb[$], yb[$];
    int v[6];
    int a, d; bit e;
    bit bad_req, bad_pix, bad_cnt, bad_done;
    xb = '{0, 120, 314, 318, 325};
    yb = '{0, 100, 236, 242};
    lat_cfg = 0; rand_stall = 1'b1; spur_en = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int bx0, by0;
      bx0 = xb[$urandom_range(0, 4)];
      by0 = yb[$urandom_range(0, 3)];
      for (int k = 0; k < 3; k++) begin
        v[2*k]   = bx0 + int'($urandom_range(0, 7));
        v[2*k+1] = by0 + int'($urandom_range(0, 7));
      end
      build_exp(v[0], v[1], v[2], v[3], v[4], v[5]);
      run_tri(v[0], v[1], v[2], v[3], v[4], v[5], a, d, e);
      bad_req  = !same_q(req_x, exp_rx) || !same_q(req_y, exp_ry);
      bad_pix  = !same_q(pix_x, exp_px) || !same_q(pix_y, exp_py) || unstable;
      bad_cnt  = (bus.pixel_count_out !== 64'(exp_px.size()));
      bad_done = (done_cnt != 1) || (bus.error_out !== 1'b0);
      n_checks++;
      if (bad_req || bad_pix || bad_cnt || bad_done) begin
        n_fail++;
        $display("FAIL random_%0d: req %0d/%0d pix %0d/%0d cnt %0d done %0d err %b, required matching model",
                 t, req_x.size(), exp_rx.size(), pix_x.size(), exp_px.size(),
                 bus.pixel_count_out, done_cnt, bus.error_out);
      end
    end
    lat_cfg = 2; rand_stall = 1'b0; spur_en = 1'b0;
  endtask

  initial begin
    bus.tri_valid_in = 1'b0;
    bus.vertex_ax = '0; bus.vertex_ay = '0;
    bus.vertex_bx = '0; bus.vertex_by = '0;
    bus.vertex_cx = '0; bus.vertex_cy = '0;
    test_reset();
    test_basic();
    test_stall();
    test_offscreen();
    test_clip();
    test_timeout();
    test_reset_mid_emit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_raster_ctrl.md
TRI_RASTER_CTRL -- requirements
Module: tri_raster_ctrl

Interface
REQ-001 Parameter SYS_BIT_WIDTH, default 32: width of every coordinate.
REQ-002 Parameter SCREEN_W, default 320: screen width in pixels; valid x is 0..SCREEN_W-1.
REQ-003 Parameter SCREEN_H, default 240: screen height in pixels; valid y is 0..SCREEN_H-1.
REQ-004 Parameter TIMEOUT, default 15: maximum number of cycles to wait for a tester result.
REQ-005 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-007 tri_valid_in  input  1  triangle offer; accepted when tri_valid_in && tri_ready_out.
REQ-008 vertex_ax, vertex_ay, vertex_bx, vertex_by, vertex_cx, vertex_cy  input  SYS_BIT_WIDTH each  unsigned vertex coordinates.
REQ-009 tri_ready_out  output  1  high only in IDLE.
REQ-010 test_valid_out  output  1  single-cycle strobe to the point-in-triangle tester.
REQ-011 test_vertex_ax..test_vertex_cy, test_point_x, test_point_y  output  SYS_BIT_WIDTH each  registered tester operands.
REQ-012 test_valid_in, test_inside_in  input  1 each  tester result strobe and verdict.
REQ-013 pixel_valid_out, pixel_x_out, pixel_y_out  output  1, SYS_BIT_WIDTH, SYS_BIT_WIDTH  covered-pixel stream.
REQ-014 pixel_ready_in  input  1  downstream accept.
REQ-015 done_out  output  1  one-cycle pulse when a triangle finishes.
REQ-016 error_out  output  1  sticky flag set on tester timeout.
REQ-017 pixel_count_out  output  2*SYS_BIT_WIDTH  covered-pixel count of the last or current triangle.

Function
REQ-018 The FSM SHALL have the states IDLE, BBOX, ISSUE, WAIT, EMIT, NEXT and FINISH.
REQ-019 IDLE: on accept, latch the six vertices into the test_vertex_* registers, clear pixel_count_out and go to BBOX.
REQ-020 BBOX (1 cycle): compute xmin/xmax/ymin/ymax as the min/max of the vertex coordinates (unsigned compare).
REQ-021 BBOX clipping: clamp xmax to SCREEN_W-1 and ymax to SCREEN_H-1.
REQ-022 BBOX exit: if xmin>SCREEN_W-1 or ymin>SCREEN_H-1, go to FINISH with zero pixels; otherwise set x=xmin, y=ymin and go to ISSUE.
REQ-023 ISSUE: drive test_point=(x,y), assert test_valid_out for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-024 At most one tester request SHALL be outstanding at any time.
REQ-025 WAIT: increment the timeout counter each cycle.
REQ-026 WAIT on test_valid_in: if test_inside_in=1 go to EMIT, else go to NEXT.
REQ-027 WAIT timeout: if the counter reaches TIMEOUT with no result, set error_out and go to FINISH, abandoning the triangle.
REQ-028 A test_valid_in arriving in any state other than WAIT SHALL be ignored.
REQ-029 EMIT: hold pixel_valid_out=1 with stable pixel_x_out/pixel_y_out until pixel_ready_in=1.
REQ-030 EMIT handshake: on the handshake cycle, increment pixel_count_out and go to NEXT; pixel_ready_in already high SHALL complete EMIT in 1 cycle.
REQ-031 NEXT raster order is row-major, x innermost: if x<xmax then x=x+1; else x=xmin and y=y+1.
REQ-032 NEXT: if x==xmax and y==ymax, go to FINISH; otherwise go to ISSUE.
REQ-033 FINISH: pulse done_out for 1 cycle, then go to IDLE; pixel_count_out holds until the next accept.
REQ-034 Throughput per bbox pixel: ISSUE(1) + WAIT(tester latency) + NEXT(1), plus EMIT cycles for covered pixels.
REQ-035 Degenerate triangles (zero area, single point) SHALL be scanned normally; the tester verdict decides coverage.
REQ-036 error_out SHALL clear only on reset or on the next accepted triangle.

Reset
REQ-037 While rst_n_in=0: FSM=IDLE; tri_ready_out=1; all other outputs 0.
REQ-038 Reset asserted mid-triangle SHALL abort immediately with no done_out pulse.
REQ-039 A tester result arriving after reset release SHALL be ignored.

Verification
REQ-040 Vertices (2,2),(5,2),(2,5), tester model with 2-cycle latency (correct verdict) -> 16 requests in row-major order; 10 pixels emitted; pixel_count_out=10; one done_out pulse.
REQ-041 Same triangle with pixel_ready_in low for 3 cycles on the first pixel -> pixel (2,2) held stable for 4 cycles; no further tester request during the stall.
REQ-042 Vertices (400,10),(500,20),(450,30) with SCREEN_W=320 -> no tester requests; done_out pulses 2 cycles after accept; pixel_count_out=0.
REQ-043 Vertices (318,0),(330,0),(318,1) -> x clamped to 319; exactly 4 requests: (318,0),(319,0),(318,1),(319,1).
REQ-044 Tester never responds -> error_out=1 after TIMEOUT WAIT cycles; done_out pulses; next accept clears error_out.
REQ-045 rst_n_in pulsed low during EMIT -> outputs zero asynchronously; tri_ready_out=1; no done_out pulse.
